// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package instruction_fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH,
      WAIT,
      DRAIN,
      HALT
   } fetch_state_t;

   typedef enum logic [1:0] {
      FC_NONE,
      FC_MISALIGN,
      FC_ACCESS
   } fetch_cause_t;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Two-entry instruction queue between fetch and decode.
module fetch_queue
   import instruction_fetch_unit_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            push,
   input  logic            pop,
   input  logic            flush,
   input  logic [31:0]     push_data,
   input  logic [XLEN-1:0] push_pc,
   input  logic            push_fault,
   input  fetch_cause_t    push_cause,
   output logic [31:0]     head_data,
   output logic [XLEN-1:0] head_pc,
   output logic            head_fault,
   output fetch_cause_t    head_cause,
   output logic            full,
   output logic            empty,
   output logic [1:0]      count
);

   logic [31:0]     data_q  [2];
   logic [XLEN-1:0] pc_q    [2];
   logic            fault_q [2];
   fetch_cause_t    cause_q [2];
   logic            rd_ptr;
   logic            wr_ptr;
   logic [1:0]      cnt;
   logic            do_pop;

   assign empty  = (cnt == 2'd0);
   assign full   = (cnt == 2'd2);
   assign count  = cnt;
   assign do_pop = pop && !empty;

   assign head_data  = data_q[rd_ptr];
   assign head_pc    = pc_q[rd_ptr];
   assign head_fault = fault_q[rd_ptr];
   assign head_cause = cause_q[rd_ptr];

   always_ff @(posedge clk) begin
      if (!resetn || flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push)
            wr_ptr <= ~wr_ptr;
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         cnt <= cnt + {1'b0, push} - {1'b0, do_pop};
      end
   end

   // At full with a pop, wr_ptr == rd_ptr and the head slot is reused.
   always_ff @(posedge clk) begin
      if (resetn && !flush && push) begin
         data_q[wr_ptr]  <= push_data;
         pc_q[wr_ptr]    <= push_pc;
         fault_q[wr_ptr] <= push_fault;
         cause_q[wr_ptr] <= push_cause;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, instruction memory requests, redirect handling and
// fault reporting, feeding decode through a two-entry queue.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int          XLEN     = 64,
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          QDEPTH   = 2
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [31:0]     imem_addr,
   input  logic            imem_valid,
   input  logic            imem_ready,
   input  logic            imem_err,
   input  logic [XLEN-1:0] imem_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst_data,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_fault,
   output logic [1:0]      inst_cause
);

   localparam int SHIFT = $clog2(XLEN / 8);
   localparam logic [XLEN-1:0] PC_INIT = RESET_PC[XLEN-1:0];

   function automatic logic [31:0] word_idx(input logic [XLEN-1:0] a);
      logic [XLEN-1:0] s;
      s = a >> SHIFT;
      return s[31:0];
   endfunction

   fetch_state_t    state, state_d;
   logic [XLEN-1:0] pc, pc_d;
   logic            outstanding, req_d;
   logic [31:0]     addr_d;
   logic            push;
   logic [31:0]     push_data;
   logic            push_fault;
   fetch_cause_t    push_cause;
   logic [31:0]     head_data;
   logic            head_fault;
   fetch_cause_t    head_cause;
   logic            full, empty;
   logic [1:0]      count;
   logic [63:0]     data_ext;
   logic [31:0]     slice;
   logic            unused;

   assign unused   = ^{imem_ready, full};
   assign imem_req = outstanding;
   assign data_ext = 64'(imem_data);
   assign slice    = (XLEN == 64 && pc[2]) ? data_ext[63:32] : data_ext[31:0];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= FETCH;
         pc          <= PC_INIT;
         outstanding <= 1'b0;
         imem_addr   <= word_idx(PC_INIT);
      end else begin
         state       <= state_d;
         pc          <= pc_d;
         outstanding <= req_d;
         imem_addr   <= addr_d;
      end
   end

   always_comb begin
      state_d    = state;
      pc_d       = pc;
      req_d      = outstanding;
      addr_d     = imem_addr;
      push       = 1'b0;
      push_data  = NOP_INSN;
      push_fault = 1'b0;
      push_cause = FC_NONE;
      unique case (state)
         FETCH: begin
            // A slot is reserved before issuing, so a response never overflows.
            if (count < 2'(QDEPTH)) begin
               if (pc[1:0] != 2'b00) begin
                  push       = 1'b1;
                  push_fault = 1'b1;
                  push_cause = FC_MISALIGN;
                  state_d    = HALT;
               end else begin
                  req_d   = 1'b1;
                  addr_d  = word_idx(pc);
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (imem_valid) begin
               req_d = 1'b0;
               push  = 1'b1;
               if (imem_err) begin
                  push_fault = 1'b1;
                  push_cause = FC_ACCESS;
                  state_d    = HALT;
               end else begin
                  push_data = slice;
                  pc_d      = pc + XLEN'(4);
                  state_d   = FETCH;
               end
            end
         end
         DRAIN: begin
            if (imem_valid) begin
               req_d   = 1'b0;
               state_d = FETCH;
            end
         end
         HALT: begin
         end
      endcase
      // Redirect wins; a still-pending request is held and its reply dropped.
      if (redirect_valid) begin
         pc_d   = redirect_pc;
         push   = 1'b0;
         addr_d = imem_addr;
         if (outstanding && !imem_valid) begin
            req_d   = 1'b1;
            state_d = DRAIN;
         end else begin
            req_d   = 1'b0;
            state_d = FETCH;
         end
      end
   end

   fetch_queue #(.XLEN(XLEN)) u_queue (
      .clk        (clk),
      .resetn     (resetn),
      .push       (push),
      .pop        (inst_valid && inst_ready),
      .flush      (redirect_valid),
      .push_data  (push_data),
      .push_pc    (pc),
      .push_fault (push_fault),
      .push_cause (push_cause),
      .head_data  (head_data),
      .head_pc    (inst_pc),
      .head_fault (head_fault),
      .head_cause (head_cause),
      .full       (full),
      .empty      (empty),
      .count      (count)
   );

   assign inst_valid = !empty;
   assign inst_data  = head_data;
   assign inst_fault = !empty && head_fault;
   assign inst_cause = empty ? 2'b00 : head_cause;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a one-cycle memory model.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic        imem_ready;
   logic        imem_err;
   logic [63:0] imem_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [63:0] inst_pc;
   logic        inst_fault;
   logic [1:0]  inst_cause;

   int checks = 0;
   int errors = 0;

   logic [63:0] mem [32];
   logic        mem_hold = 1'b0;
   logic        err_en = 1'b0;
   logic [31:0] err_addr = 32'd0;
   logic        inject_stale = 1'b0;
   logic [31:0] addr_log [$];

   always #5 clk = ~clk;

   assign imem_ready = imem_valid;

   instruction_fetch_unit #(
      .XLEN     (64),
      .RESET_PC (64'h0),
      .QDEPTH   (2)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_valid     (imem_valid),
      .imem_ready     (imem_ready),
      .imem_err       (imem_err),
      .imem_data      (imem_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_fault     (inst_fault),
      .inst_cause     (inst_cause)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory: answers one cycle after it sees a request, unless held.
   initial begin
      imem_valid = 1'b0;
      imem_err   = 1'b0;
      imem_data  = 64'h0;
      forever begin
         @(posedge clk);
         #1;
         if (inject_stale) begin
            imem_valid = 1'b1;
            imem_err   = 1'b0;
            imem_data  = 64'hDEAD_BEEF_DEAD_BEEF;
         end else if (imem_req && !imem_valid && !mem_hold) begin
            imem_valid = 1'b1;
            imem_data  = mem[imem_addr[4:0]];
            imem_err   = err_en && (imem_addr == err_addr);
         end else begin
            imem_valid = 1'b0;
            imem_err   = 1'b0;
         end
      end
   end

   initial begin
      logic prev;
      prev = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (imem_req && !prev)
            addr_log.push_back(imem_addr);
         prev = imem_req;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic take(input string tag, input logic [31:0] d,
                       input logic [63:0] p, input logic f,
                       input logic [1:0] c);
      int n;
      n = 0;
      while (!inst_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!inst_valid) begin
         check({tag, "_timeout"}, 64'd0, 64'd1);
      end else begin
         check({tag, "_data"}, 64'(inst_data), 64'(d));
         check({tag, "_pc"}, inst_pc, p);
         check({tag, "_fault"}, 64'(inst_fault), 64'(f));
         check({tag, "_cause"}, 64'(inst_cause), 64'(c));
      end
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
   endtask

   task automatic redirect(input logic [63:0] p);
      redirect_valid = 1'b1;
      redirect_pc    = p;
      @(negedge clk);
      redirect_valid = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic wait_req(input string tag);
      int n;
      n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(imem_req), 64'd1);
   endtask

   task automatic check_addr(input string tag, input int idx,
                             input logic [31:0] exp);
      if (addr_log.size() > idx)
         check(tag, 64'(addr_log[idx]), 64'(exp));
      else
         check({tag, "_missing"}, 64'(addr_log.size()), 64'(idx + 1));
   endtask

   initial begin
      int n0;
      for (int i = 0; i < 32; i++)
         mem[i] = {32'hC000_0004 | (32'(i) << 3), 32'hC000_0000 | (32'(i) << 3)};
      mem[0] = 64'h0050_0093_0010_0013;
      mem[1] = 64'h0000_0073_0020_8133;
      resetn         = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      inst_ready     = 1'b0;
      @(negedge clk);
      @(negedge clk);

      check("rst_req", 64'(imem_req), 64'd0);
      check("rst_valid", 64'(inst_valid), 64'd0);
      check("rst_fault", 64'(inst_fault), 64'd0);
      check("rst_cause", 64'(inst_cause), 64'd0);
      check("rst_addr", 64'(imem_addr), 64'd0);

      // In-order stream across both halves of two words
      n0 = addr_log.size();
      resetn = 1'b1;
      take("t1_i0", 32'h0010_0013, 64'h0, 1'b0, 2'd0);
      take("t1_i1", 32'h0050_0093, 64'h4, 1'b0, 2'd0);
      take("t1_i2", 32'h0020_8133, 64'h8, 1'b0, 2'd0);
      take("t1_i3", 32'h0000_0073, 64'hC, 1'b0, 2'd0);
      check_addr("t1_a0", n0, 32'd0);
      check_addr("t1_a1", n0 + 1, 32'd0);
      check_addr("t1_a2", n0 + 2, 32'd1);
      check_addr("t1_a3", n0 + 3, 32'd1);

      // Decode stall: queue fills to two, then requests stop
      do_reset();
      n0 = addr_log.size();
      repeat (10) @(negedge clk);
      check("t2_req_low", 64'(imem_req), 64'd0);
      check("t2_valid", 64'(inst_valid), 64'd1);
      check("t2_nreq", 64'(addr_log.size() - n0), 64'd2);
      take("t2_i0", 32'h0010_0013, 64'h0, 1'b0, 2'd0);
      take("t2_i1", 32'h0050_0093, 64'h4, 1'b0, 2'd0);
      take("t2_i2", 32'h0020_8133, 64'h8, 1'b0, 2'd0);
      take("t2_i3", 32'h0000_0073, 64'hC, 1'b0, 2'd0);

      // Redirect while a request is pending
      mem_hold = 1'b1;
      do_reset();
      n0 = addr_log.size();
      wait_req("t3_req_rise");
      redirect(64'h40);
      check("t3_empty", 64'(inst_valid), 64'd0);
      check("t3_drain_req", 64'(imem_req), 64'd1);
      check("t3_drain_addr", 64'(imem_addr), 64'd0);
      mem_hold = 1'b0;
      take("t3_i0", 32'hC000_0040, 64'h40, 1'b0, 2'd0);
      check_addr("t3_a1", n0 + 1, 32'd8);

      // Misaligned target: fault entry, then halt
      redirect(64'h42);
      take("t4_f", 32'h0000_0013, 64'h42, 1'b1, 2'd1);
      n0 = addr_log.size();
      repeat (5) @(negedge clk);
      check("t4_halt_req", 64'(imem_req), 64'd0);
      check("t4_nreq", 64'(addr_log.size() - n0), 64'd0);
      check("t4_empty", 64'(inst_valid), 64'd0);
      redirect(64'h0);
      take("t4_restart", 32'h0010_0013, 64'h0, 1'b0, 2'd0);

      // Access error at 0x10
      err_en   = 1'b1;
      err_addr = 32'd2;
      redirect(64'h10);
      take("t5_f", 32'h0000_0013, 64'h10, 1'b1, 2'd2);
      n0 = addr_log.size();
      repeat (5) @(negedge clk);
      check("t5_halt_req", 64'(imem_req), 64'd0);
      check("t5_nreq", 64'(addr_log.size() - n0), 64'd0);
      err_en = 1'b0;

      // Reset in WAIT with a stale response right after
      mem_hold = 1'b1;
      redirect(64'h20);
      wait_req("t6_req_rise");
      resetn       = 1'b0;
      inject_stale = 1'b1;
      @(negedge clk);
      resetn       = 1'b1;
      inject_stale = 1'b0;
      mem_hold     = 1'b0;
      check("t6_req", 64'(imem_req), 64'd0);
      check("t6_valid", 64'(inst_valid), 64'd0);
      check("t6_addr", 64'(imem_addr), 64'd0);
      take("t6_i0", 32'h0010_0013, 64'h0, 1'b0, 2'd0);
      take("t6_i1", 32'h0050_0093, 64'h4, 1'b0, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
